// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: hazard FSM encoding, stall/flush bit indices, register-select width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Default architectural register-select width (32 registers).
  localparam int REG_SEL = 5;

  // Hazard controller FSM states.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // stall vector: {exmem, idex, ifid, pc}, 1 = hold the register.
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;

  // flush vector: {memwb, exmem, idex, ifid}, 1 = load a NOP bubble.
  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXMEM = 2;
  localparam int FLUSH_MEMWB = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clr returns it to zero.
// Latency: count reflects inc on the next rising edge of clk.
// Backpressure: none; inc is sampled every cycle.
//   clk   : clock, rising edge
//   clr   : synchronous clear, overrides inc
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, data-memory wait/timeout handling.
// Latency: stall/flush are combinational (zero cycles); mem_fault and counters update on the next edge.
// Backpressure: a memory wait holds every pipeline register; a timeout releases it and raises mem_fault.
//   clk, rst               : clock and synchronous active-high reset
//   id_rs1/id_rs2/id_use   : ID-stage source registers and which of them are read
//   ex_rd/ex_mem_read      : EX-stage destination and load flag
//   mem_req/mem_ready      : MEM-stage access and data-memory completion
//   redirect               : taken branch/jump resolved in MEM
//   fault_clr              : clears the sticky mem_fault
//   stall/flush            : per-register hold and bubble controls
//   mem_fault              : sticky memory-timeout flag
//   stall_count/flush_count: saturating event counters
module pipeline_hazard_ctrl #(
  parameter int REG_SEL     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   id_rs1,
  input  logic [REG_SEL-1:0]   id_rs2,
  input  logic [1:0]           id_use,
  input  logic [REG_SEL-1:0]   ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 redirect,
  input  logic                 fault_clr,
  output logic [3:0]           stall,
  output logic [3:0]           flush,
  output logic                 mem_fault,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  import cpu_pkg::*;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       mem_wait;
  logic       timeout;
  logic       load_use;
  logic       redirect_taken;

  // Memory wait is evaluated the same way in RUN and WAIT; the state only
  // decides whether the wait counter is loaded or advanced.
  assign mem_wait = mem_req && !mem_ready;
  assign timeout  = (state == ST_WAIT) && mem_wait && (wait_cnt == TIMEOUT_VAL);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use[0] && (ex_rd == id_rs1)) ||
                     (id_use[1] && (ex_rd == id_rs2)));

  // A timeout cycle always carries mem_wait, so this also excludes it.
  assign redirect_taken = redirect && !mem_wait && !rst;

  // Priority: reset, timeout, memory wait, redirect, load-use. A redirect
  // wins over load-use because the dependent ID instruction is flushed anyway.
  always_comb begin
    stall = '0;
    flush = '0;
    if (rst) begin
      flush = 4'b1111;
    end else if (timeout) begin
      // Abandon the access: let the pipeline move and bubble MEM/WB.
      flush[FLUSH_MEMWB] = 1'b1;
    end else if (mem_wait) begin
      stall              = 4'b1111;
      flush[FLUSH_MEMWB] = 1'b1;
    end else if (redirect) begin
      flush[FLUSH_IFID]  = 1'b1;
      flush[FLUSH_IDEX]  = 1'b1;
      flush[FLUSH_EXMEM] = 1'b1;
    end else if (load_use) begin
      stall[STALL_PC]   = 1'b1;
      stall[STALL_IFID] = 1'b1;
      flush[FLUSH_IDEX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      // Set takes precedence so a coincident clear cannot lose a fault.
      if (timeout) begin
        mem_fault <= 1'b1;
      end else if (fault_clr) begin
        mem_fault <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (mem_wait) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (!mem_wait || timeout) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall[STALL_PC]),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect_taken),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_SEL, default 5: register-select width.
REQ-002 Parameter MEM_TIMEOUT, default 16: maximum memory-wait cycles before a fault (valid range 2..255).
REQ-003 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-004 The block SHALL use one clock, and its reset is synchronous and active-high; ports are clk and rst.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_rs1  in  REG_SEL  source register 1 of the instruction in ID.
REQ-008 id_rs2  in  REG_SEL  source register 2 of the instruction in ID.
REQ-009 id_use  in  2  bit0: ID reads rs1; bit1: ID reads rs2.
REQ-010 ex_rd  in  REG_SEL  destination register of the instruction in EX.
REQ-011 ex_mem_read  in  1  the instruction in EX is a load.
REQ-012 mem_req  in  1  the instruction in MEM accesses data memory.
REQ-013 mem_ready  in  1  data memory completes the access this cycle.
REQ-014 redirect  in  1  taken branch or jump resolved in MEM.
REQ-015 fault_clr  in  1  clears mem_fault.
REQ-016 stall  out  4  hold enables {exmem, idex, ifid, pc}; 1 = hold.
REQ-017 flush  out  4  bubble inserts {memwb, exmem, idex, ifid}; 1 = clear to NOP.
REQ-018 mem_fault  out  1  sticky memory-timeout flag.
REQ-019 stall_count  out  CNT_WIDTH  count of cycles in which stall[0] is 1.
REQ-020 flush_count  out  CNT_WIDTH  count of redirect events.

Function
REQ-021 stall and flush SHALL be combinational from the inputs and the current state, with zero-cycle latency.
REQ-022 Load-use hazard is defined as ex_mem_read AND ex_rd!=0 AND ((id_use[0] AND ex_rd==id_rs1) OR (id_use[1] AND ex_rd==id_rs2)).
REQ-023 On a load-use hazard with no higher-priority event, the block SHALL drive stall=4'b0011 and flush=4'b0010 for exactly one cycle.
REQ-024 On redirect with no memory wait, the block SHALL drive flush=4'b0111 and stall=0; flush_count SHALL increment by 1 on the next edge.
REQ-025 Memory wait is defined as mem_req AND NOT mem_ready, in RUN or WAIT.
REQ-026 During a memory wait the block SHALL drive stall=4'b1111 and flush=4'b1000.
REQ-027 Priority, highest first: memory wait, redirect, load-use. A lower-priority event that is masked SHALL be re-evaluated in the cycle after the wait ends.
REQ-028 The FSM SHALL have two states, RUN and WAIT, plus an 8-bit wait counter.
REQ-029 RUN to WAIT on a memory wait, with the counter loaded to 1.
REQ-030 WAIT to RUN when mem_ready=1; that cycle stalls nothing due to memory.
REQ-031 In WAIT with NOT mem_ready and counter==MEM_TIMEOUT, the block SHALL drive stall=0 and flush=4'b1000 for one cycle, set mem_fault, and return to RUN. Otherwise the counter increments.
REQ-032 mem_fault SHALL be sticky; fault_clr clears it. A timeout and fault_clr in the same cycle SHALL leave mem_fault=1.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.
REQ-034 A redirect in the same cycle as a load-use hazard SHALL suppress the load-use stall, because the ID instruction is being flushed.

Reset
REQ-035 rst SHALL set the state to RUN, the wait counter to 0, mem_fault to 0, and both counters to 0, overriding all other inputs, including mid-WAIT.
REQ-036 While rst=1, stall and flush SHALL be driven to 4'b0000 and 4'b1111 respectively.

Structure
REQ-037 A shared package cpu_pkg SHALL hold the FSM state encoding, the stall/flush bit-index constants, and REG_SEL.
REQ-038 One sub-module, sat_counter (parametrised width, inc, clr), SHALL be instantiated twice.
REQ-039 The forwarding logic SHALL remain a separate unit and is not part of this block.

Verification
REQ-040 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use=01 for one cycle -> stall=0011, flush=0010; stall_count=1 after the edge.
REQ-041 Load-use to x0: ex_rd=0, id_rs1=0 -> stall=0000, flush=0000.
REQ-042 Redirect during load-use: redirect=1 with the REQ-040 hazard -> flush=0111, stall=0000; flush_count=1.
REQ-043 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> stall=1111 and flush=1000 for 3 cycles, then 0000/0000; stall_count=3.
REQ-044 Timeout, MEM_TIMEOUT=4: mem_ready held 0 -> 4 stalled cycles, then one cycle with stall=0000 and flush=1000; mem_fault=1 and remains 1 until fault_clr.
REQ-045 Reset mid-WAIT: assert rst in the 2nd wait cycle -> the next cycle shows state RUN and counters 0; with mem_ready=1 after reset, there is no stall.
